// File: rtl/freelist_queue.sv
// Free physical register list for register rename.
// A circular buffer of free physical register numbers with three pointers:
// specHead (next entry handed to dispatch), retireHead (oldest allocation not
// yet committed) and tail (where released registers are written back).
// Entries between retireHead and specHead are speculative allocations that a
// branch recovery hands back by rewinding specHead to retireHead.
module freelist_queue #(
    parameter int WAYS   = 3,
    parameter int PR_NUM = 64,
    parameter int AR_NUM = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [WAYS-1:0]                     new_pr_en,
    output logic [WAYS-1:0][$clog2(PR_NUM)-1:0] new_pr_idx,
    output logic [WAYS-1:0]                     new_pr_valid,
    output logic [$clog2(PR_NUM-AR_NUM):0]      free_count,
    input  logic [WAYS-1:0]                     retire_valid,
    input  logic [WAYS-1:0][$clog2(PR_NUM)-1:0] retire_told_idx,
    input  logic                                br_recover_enable,
    output logic                                overflow_err
);

    localparam int D  = PR_NUM - AR_NUM;
    localparam int IW = $clog2(D);
    localparam int PW = IW + 1;
    localparam int RW = $clog2(PR_NUM);

    logic [RW-1:0] slots_q [D];
    logic [RW-1:0] slots_d [D];

    logic [PW-1:0] specHead_q;
    logic [PW-1:0] specHead_d;
    logic [PW-1:0] retireHead_q;
    logic [PW-1:0] retireHead_d;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] tail_d;
    logic          overflow_q;
    logic          overflow_d;

    logic [PW-1:0] freeCnt;
    logic [PW-1:0] grantCnt;
    logic [PW-1:0] pushCap;
    logic [PW-1:0] pushCnt;
    logic          dropped;

    // Free entries are those between specHead and tail; registered state only.
    assign freeCnt      = tail_q - specHead_q;
    assign free_count   = freeCnt;
    assign overflow_err = overflow_q;

    // Grant requesting ways in order while free entries remain; each grant reads the next entry.
    always_comb begin
        grantCnt     = '0;
        new_pr_valid = '0;
        new_pr_idx   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (new_pr_en[i] && (grantCnt < freeCnt)) begin
                new_pr_valid[i] = 1'b1;
                new_pr_idx[i]   = slots_q[IW'(specHead_q + grantCnt)];
                grantCnt        = grantCnt + PW'(1);
            end
        end
    end

    // Compact released registers into the tail; only as many as there are outstanding allocations fit.
    always_comb begin
        slots_d = slots_q;
        pushCap = PW'(D) - freeCnt;
        pushCnt = '0;
        dropped = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (retire_valid[i]) begin
                if (pushCnt < pushCap) begin
                    slots_d[IW'(tail_q + pushCnt)] = retire_told_idx[i];
                    pushCnt = pushCnt + PW'(1);
                end else begin
                    dropped = 1'b1;
                end
            end
        end
    end

    // Pointer updates; recovery rewinds specHead to the post-retire retireHead and discards grants.
    always_comb begin
        tail_d       = tail_q + pushCnt;
        retireHead_d = retireHead_q + pushCnt;
        specHead_d   = br_recover_enable ? retireHead_d : (specHead_q + grantCnt);
        overflow_d   = overflow_q | dropped;
    end

    // State registers; reset refills the list with the registers above the architectural set.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int j = 0; j < D; j++) begin
                slots_q[j] <= RW'(AR_NUM + j);
            end
            specHead_q   <= '0;
            retireHead_q <= '0;
            tail_q       <= PW'(D);
            overflow_q   <= 1'b0;
        end else begin
            slots_q      <= slots_d;
            specHead_q   <= specHead_d;
            retireHead_q <= retireHead_d;
            tail_q       <= tail_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_freelist_queue.sv
// Self-checking bench for freelist_queue: directed scenarios plus a randomized
// run compared against a queue-based model of free and in-flight registers.
module tb_freelist_queue;

    localparam int WAYS = 3;
    localparam int D    = 32;

    logic                 clock;
    logic                 resetN;
    logic [WAYS-1:0]      newPrEn;
    logic [WAYS-1:0][5:0] newPrIdx;
    logic [WAYS-1:0]      newPrValid;
    logic [5:0]           freeCount;
    logic [WAYS-1:0]      retireValid;
    logic [WAYS-1:0][5:0] retireTold;
    logic                 brRecover;
    logic                 overflowErr;

    int total;
    int bad;

    // Model: freeQ holds free registers in hand-out order, specQ holds
    // allocations not yet committed, oldest first.
    int              freeQ[$];
    int              specQ[$];
    bit              ovfM;
    logic [WAYS-1:0] expValid;
    int              expIdx[WAYS];
    int              expGrants;

    freelist_queue #(.WAYS(3), .PR_NUM(64), .AR_NUM(32)) dut (
        .clock            (clock),
        .reset            (resetN),
        .new_pr_en        (newPrEn),
        .new_pr_idx       (newPrIdx),
        .new_pr_valid     (newPrValid),
        .free_count       (freeCount),
        .retire_valid     (retireValid),
        .retire_told_idx  (retireTold),
        .br_recover_enable(brRecover),
        .overflow_err     (overflowErr)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic modelReset();
        freeQ.delete();
        specQ.delete();
        for (int j = 0; j < D; j++) freeQ.push_back(32 + j);
        ovfM = 1'b0;
    endtask

    task automatic modelOutputs();
        int g;
        g = 0;
        for (int i = 0; i < WAYS; i++) begin
            expValid[i] = 1'b0;
            expIdx[i]   = 0;
            if (newPrEn[i] && g < freeQ.size()) begin
                expValid[i] = 1'b1;
                expIdx[i]   = freeQ[g];
                g++;
            end
        end
        expGrants = g;
    endtask

    // Advance the model by one clock with the current inputs, then pass the edge.
    task automatic tick();
        int cap;
        int pushed[$];
        modelOutputs();
        if (!resetN) begin
            modelReset();
        end else begin
            cap = D - freeQ.size();
            for (int i = 0; i < WAYS; i++) begin
                if (retireValid[i]) begin
                    if (pushed.size() < cap) pushed.push_back(int'(retireTold[i]));
                    else ovfM = 1'b1;
                end
            end
            if (!brRecover) begin
                for (int g = 0; g < expGrants; g++) specQ.push_back(freeQ.pop_front());
            end
            for (int k = 0; k < pushed.size(); k++) void'(specQ.pop_front());
            foreach (pushed[k]) freeQ.push_back(pushed[k]);
            if (brRecover) begin
                for (int i = specQ.size() - 1; i >= 0; i--) freeQ.push_front(specQ[i]);
                specQ.delete();
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic setIdle();
        newPrEn     = '0;
        retireValid = '0;
        retireTold  = '0;
        brRecover   = 1'b0;
    endtask

    task automatic doReset();
        setIdle();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        newPrEn     = 3'b111;
        retireValid = 3'b111;
        retireTold  = {6'd1, 6'd2, 6'd3};
        brRecover   = 1'b1;
        resetN      = 1'b0;
        tick();
        resetN = 1'b1;
        setIdle();
        #1;
        total++;
        if (freeCount !== 6'd32) begin bad++; $display("[TB] FAIL reset_free_count got %0d expected 32", freeCount); end
        total++;
        if (overflowErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got %b expected 0", overflowErr); end
        total++;
        if (newPrValid !== 3'b000) begin bad++; $display("[TB] FAIL reset_valid_idle got %b expected 000", newPrValid); end
        newPrEn = 3'b110;
        #1;
        total++;
        if (newPrValid !== 3'b110) begin bad++; $display("[TB] FAIL reset_valid_follows_en got %b expected 110", newPrValid); end
        setIdle();
    endtask

    task automatic test_alloc3();
        doReset();
        newPrEn = 3'b111;
        #1;
        total++;
        if (newPrIdx !== {6'd34, 6'd33, 6'd32}) begin bad++; $display("[TB] FAIL alloc3_idx got %h expected {34,33,32}", newPrIdx); end
        total++;
        if (newPrValid !== 3'b111) begin bad++; $display("[TB] FAIL alloc3_valid got %b expected 111", newPrValid); end
        tick();
        setIdle();
        #1;
        total++;
        if (freeCount !== 6'd29) begin bad++; $display("[TB] FAIL alloc3_free_count got %0d expected 29", freeCount); end
    endtask

    task automatic test_skip();
        doReset();
        newPrEn = 3'b101;
        #1;
        total++;
        if (newPrIdx[0] !== 6'd32 || newPrIdx[2] !== 6'd33) begin bad++; $display("[TB] FAIL skip_idx got w0=%0d w2=%0d expected 32,33", newPrIdx[0], newPrIdx[2]); end
        total++;
        if (newPrValid !== 3'b101 || newPrIdx[1] !== 6'd0) begin bad++; $display("[TB] FAIL skip_way1 got valid=%b idx1=%0d expected 101,0", newPrValid, newPrIdx[1]); end
        tick();
        setIdle();
        newPrEn = 3'b001;
        #1;
        total++;
        if (freeCount !== 6'd30) begin bad++; $display("[TB] FAIL skip_free_count got %0d expected 30", freeCount); end
        total++;
        if (newPrIdx[0] !== 6'd34) begin bad++; $display("[TB] FAIL skip_head_advance got %0d expected 34", newPrIdx[0]); end
        setIdle();
    endtask

    task automatic test_exhaust();
        doReset();
        newPrEn = 3'b111;
        repeat (11) tick();
        #1;
        total++;
        if (freeCount !== 6'd0) begin bad++; $display("[TB] FAIL exhaust_free_count got %0d expected 0", freeCount); end
        total++;
        if (newPrValid !== 3'b000) begin bad++; $display("[TB] FAIL exhaust_valid got %b expected 000", newPrValid); end
        newPrEn     = 3'b000;
        retireValid = 3'b111;
        retireTold  = {6'd32, 6'd21, 6'd20};
        tick();
        setIdle();
        #1;
        total++;
        if (freeCount !== 6'd3) begin bad++; $display("[TB] FAIL exhaust_refill_count got %0d expected 3", freeCount); end
        newPrEn = 3'b111;
        #1;
        total++;
        if (newPrIdx !== {6'd32, 6'd21, 6'd20} || newPrValid !== 3'b111) begin bad++; $display("[TB] FAIL exhaust_refill_idx got %h/%b expected {32,21,20}/111", newPrIdx, newPrValid); end
        setIdle();
    endtask

    task automatic test_recover();
        doReset();
        newPrEn = 3'b111;
        tick();
        tick();
        setIdle();
        retireValid = 3'b111;
        retireTold  = {6'd22, 6'd21, 6'd20};
        tick();
        setIdle();
        #1;
        total++;
        if (freeCount !== 6'd29) begin bad++; $display("[TB] FAIL recover_pre_count got %0d expected 29", freeCount); end
        brRecover = 1'b1;
        newPrEn   = 3'b111;
        #1;
        total++;
        if (newPrValid !== 3'b111) begin bad++; $display("[TB] FAIL recover_valid_driven got %b expected 111", newPrValid); end
        tick();
        setIdle();
        #1;
        total++;
        if (freeCount !== 6'd32) begin bad++; $display("[TB] FAIL recover_free_count got %0d expected 32", freeCount); end
        newPrEn = 3'b111;
        #1;
        total++;
        if (newPrIdx !== {6'd37, 6'd36, 6'd35}) begin bad++; $display("[TB] FAIL recover_head got %h expected {37,36,35}", newPrIdx); end
        setIdle();
    endtask

    task automatic test_simul_wrap();
        doReset();
        newPrEn = 3'b111;
        repeat (9) tick();
        newPrEn = 3'b001;
        tick();
        setIdle();
        #1;
        total++;
        if (freeCount !== 6'd4) begin bad++; $display("[TB] FAIL simul_pre_count got %0d expected 4", freeCount); end
        newPrEn     = 3'b111;
        retireValid = 3'b011;
        retireTold  = {6'd0, 6'd6, 6'd5};
        #1;
        total++;
        if (newPrIdx !== {6'd62, 6'd61, 6'd60}) begin bad++; $display("[TB] FAIL simul_idx got %h expected {62,61,60}", newPrIdx); end
        tick();
        setIdle();
        #1;
        total++;
        if (freeCount !== 6'd3) begin bad++; $display("[TB] FAIL simul_free_count got %0d expected 3", freeCount); end
        newPrEn = 3'b111;
        #1;
        total++;
        if (newPrIdx !== {6'd6, 6'd5, 6'd63} || newPrValid !== 3'b111) begin bad++; $display("[TB] FAIL wrap_order got %h/%b expected {6,5,63}/111", newPrIdx, newPrValid); end
        tick();
        setIdle();
        #1;
        total++;
        if (freeCount !== 6'd0) begin bad++; $display("[TB] FAIL wrap_drain got %0d expected 0", freeCount); end
    endtask

    task automatic test_overflow();
        doReset();
        retireValid = 3'b001;
        retireTold  = {6'd0, 6'd0, 6'd9};
        tick();
        setIdle();
        #1;
        total++;
        if (overflowErr !== 1'b1 || freeCount !== 6'd32) begin bad++; $display("[TB] FAIL ovf_full got err=%b count=%0d expected 1,32", overflowErr, freeCount); end
        newPrEn = 3'b001;
        tick();
        setIdle();
        retireValid = 3'b110;
        retireTold  = {6'd8, 6'd7, 6'd0};
        tick();
        setIdle();
        #1;
        total++;
        if (overflowErr !== 1'b1 || freeCount !== 6'd32) begin bad++; $display("[TB] FAIL ovf_sticky got err=%b count=%0d expected 1,32", overflowErr, freeCount); end
        newPrEn = 3'b111;
        repeat (10) tick();
        #1;
        total++;
        if (newPrValid !== 3'b011 || newPrIdx[0] !== 6'd63 || newPrIdx[1] !== 6'd7) begin bad++; $display("[TB] FAIL ovf_drop_order got valid=%b w0=%0d w1=%0d expected 011,63,7", newPrValid, newPrIdx[0], newPrIdx[1]); end
        doReset();
        total++;
        if (overflowErr !== 1'b0) begin bad++; $display("[TB] FAIL ovf_cleared got %b expected 0", overflowErr); end
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 800; c++) begin
            newPrEn     = 3'($urandom);
            retireValid = ($urandom_range(0, 1) == 0) ? 3'($urandom) : 3'b000;
            for (int i = 0; i < WAYS; i++) retireTold[i] = 6'($urandom);
            brRecover = ($urandom_range(0, 15) == 0);
            resetN    = ($urandom_range(0, 99) != 0);
            #1;
            modelOutputs();
            total++;
            if (newPrValid !== expValid) begin bad++; $display("[TB] FAIL rand_valid cycle %0d got %b expected %b", c, newPrValid, expValid); end
            for (int i = 0; i < WAYS; i++) begin
                total++;
                if (newPrIdx[i] !== 6'(expIdx[i])) begin bad++; $display("[TB] FAIL rand_idx cycle %0d way %0d got %0d expected %0d", c, i, newPrIdx[i], expIdx[i]); end
            end
            total++;
            if (freeCount !== 6'(freeQ.size())) begin bad++; $display("[TB] FAIL rand_free_count cycle %0d got %0d expected %0d", c, freeCount, freeQ.size()); end
            total++;
            if (overflowErr !== ovfM) begin bad++; $display("[TB] FAIL rand_overflow cycle %0d got %b expected %b", c, overflowErr, ovfM); end
            tick();
        end
        resetN = 1'b1;
        setIdle();
    endtask

    task automatic test_reset_midop();
        newPrEn = 3'b111;
        repeat (4) tick();
        newPrEn     = 3'b111;
        retireValid = 3'b111;
        retireTold  = {6'd1, 6'd2, 6'd3};
        brRecover   = 1'b1;
        resetN      = 1'b0;
        tick();
        resetN = 1'b1;
        setIdle();
        newPrEn = 3'b111;
        #1;
        total++;
        if (freeCount !== 6'd32 || overflowErr !== 1'b0) begin bad++; $display("[TB] FAIL midop_state got count=%0d err=%b expected 32,0", freeCount, overflowErr); end
        total++;
        if (newPrIdx !== {6'd34, 6'd33, 6'd32}) begin bad++; $display("[TB] FAIL midop_idx got %h expected {34,33,32}", newPrIdx); end
        setIdle();
    endtask

    // Run every scenario in sequence, then report.
    initial begin
        total  = 0;
        bad    = 0;
        resetN = 1'b0;
        setIdle();
        modelReset();
        test_reset();
        test_alloc3();
        test_skip();
        test_exhaust();
        test_recover();
        test_simul_wrap();
        test_overflow();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
